// File: rtl/tcpu_fetch.sv
// TCPU instruction fetch: PC, sync-read imem port, registered IR with one-entry skid.
// Optional TCPU_FETCH_PREDECODE_HALT_EN stops issuing past a fetched halt word.
module tcpu_fetch #(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          imem_re,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_rdata,
  output logic [15:0]   ir,
  output logic          ir_valid,
  output logic [AW-1:0] ir_pc,
  input  logic          stall,
  input  logic          halt,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;

  state_t        state;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] ret_pc;
  logic [AW-1:0] skid_pc;
  logic [15:0]   skid;
  logic          skid_v;
  logic          inflight;
  logic          in_fetch;
  logic          halt_go;
  logic          ir_free;
  logic          issue_blk;
  logic          issue;

  assign in_fetch = (state == S_FETCH);
  assign halt_go  = in_fetch && halt && ir_valid && !redirect;
  assign ir_free  = !ir_valid || !stall;

`ifdef TCPU_FETCH_PREDECODE_HALT_EN
  logic pd_hit;
  logic pd_block;
  // A returning halt word blocks its own successor's issue in the same cycle.
  assign pd_hit    = inflight && (imem_rdata[15:13] == 3'b000) && !imem_rdata[2] && imem_rdata[0];
  assign issue_blk = pd_block || pd_hit;
`else
  assign issue_blk = 1'b0;
`endif

  // The stall term keeps at most one word buffered: a read returning into a
  // held IR goes to the skid, and nothing else is launched behind it.
  assign issue = in_fetch && !redirect && !halt_go && !skid_v &&
                 !(stall && ir_valid && inflight) && !issue_blk;

  assign imem_re   = issue;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      ret_pc   <= '0;
      skid_pc  <= '0;
      skid     <= '0;
      skid_v   <= 1'b0;
      inflight <= 1'b0;
      ir       <= '0;
      ir_valid <= 1'b0;
      ir_pc    <= '0;
      halted   <= 1'b0;
`ifdef TCPU_FETCH_PREDECODE_HALT_EN
      pd_block <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state    <= S_FETCH;
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
`ifdef TCPU_FETCH_PREDECODE_HALT_EN
            pd_block <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          if (redirect) begin
            // Clearing inflight drops the word currently on imem_rdata.
            fetch_pc <= redirect_pc;
            ir_valid <= 1'b0;
            skid_v   <= 1'b0;
            inflight <= 1'b0;
`ifdef TCPU_FETCH_PREDECODE_HALT_EN
            pd_block <= 1'b0;
`endif
          end else if (halt_go) begin
            state    <= S_HALTED;
            halted   <= 1'b1;
            ir_valid <= 1'b0;
            skid_v   <= 1'b0;
            inflight <= 1'b0;
          end else begin
            inflight <= issue;
            if (issue) begin
              fetch_pc <= fetch_pc + 1'b1;
              ret_pc   <= fetch_pc;
            end
            if (ir_free) begin
              if (skid_v) begin
                ir       <= skid;
                ir_pc    <= skid_pc;
                ir_valid <= 1'b1;
                skid_v   <= inflight;
                if (inflight) begin
                  skid    <= imem_rdata;
                  skid_pc <= ret_pc;
                end
              end else if (inflight) begin
                ir       <= imem_rdata;
                ir_pc    <= ret_pc;
                ir_valid <= 1'b1;
              end else begin
                ir_valid <= 1'b0;
              end
            end else if (inflight) begin
              skid    <= imem_rdata;
              skid_pc <= ret_pc;
              skid_v  <= 1'b1;
            end
`ifdef TCPU_FETCH_PREDECODE_HALT_EN
            if (pd_hit) pd_block <= 1'b1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcpu_fetch.sv
// Directed + randomized bench for tcpu_fetch; a delivered-stream scoreboard
// tracks which address the decoder should see next.
module tb_tcpu_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stall = 1'b0, halt = 1'b0, redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        imem_re, ir_valid, halted;
  logic [7:0]  imem_addr, ir_pc;
  logic [15:0] imem_rdata = '0, ir;
  logic [15:0] mem [256];

  // Narrow instance for PC wrap
  logic        start4 = 1'b0, zero4 = 1'b0;
  logic [3:0]  rpc4 = '0;
  logic        imem_re4, ir_valid4, halted4;
  logic [3:0]  imem_addr4, ir_pc4;
  logic [15:0] imem_rdata4 = '0, ir4;
  logic [15:0] mem4 [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_re)  imem_rdata  <= mem[imem_addr];
  always @(posedge clk) if (imem_re4) imem_rdata4 <= mem4[imem_addr4];

  tcpu_fetch #(.AW(8), .RESET_PC(8'd0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_re(imem_re), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ir(ir), .ir_valid(ir_valid), .ir_pc(ir_pc),
    .stall(stall), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  tcpu_fetch #(.AW(4), .RESET_PC(4'd14)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .imem_re(imem_re4), .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
    .ir(ir4), .ir_valid(ir_valid4), .ir_pc(ir_pc4),
    .stall(zero4), .halt(zero4), .redirect(zero4), .redirect_pc(rpc4),
    .halted(halted4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the next cycle with ir_valid=1 (inputs left untouched).
  task automatic wait_valid(input string tag, output logic [15:0] w, output logic [7:0] p);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); #1;
      if (ir_valid) got = 1'b1;
    end
    chk(tag, got, 1'b1);
    w = ir;
    p = ir_pc;
  endtask

  initial begin
    logic [15:0] w;
    logic [7:0]  p;
    logic [7:0]  exp_pc;
    logic        found;
    int          delivered;
    logic [3:0]  wrap_exp [4];

    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    for (int i = 0; i < 16; i++)  mem4[i] = 16'h5a00 | 16'(i);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ir_valid", ir_valid, 1'b0);
    chk("rst_ir", ir, 16'h0);
    chk("rst_ir_pc", ir_pc, 8'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_imem_re", imem_re, 1'b0);
    chk("rst_imem_addr", imem_addr, 8'h0);
    rst_n = 1'b1;

    // Start and straight-line delivery
    @(negedge clk); start = 1'b1; #1;
    chk("idle_no_re", imem_re, 1'b0);
    @(negedge clk); start = 1'b0; #1;
    chk("c1_re", imem_re, 1'b1);
    chk("c1_addr", imem_addr, 8'h0);
    @(negedge clk); #1;
    chk("c2_ir_valid", ir_valid, 1'b0);
    @(negedge clk); #1;
    chk("c3_ir_valid", ir_valid, 1'b1);
    chk("c3_ir", ir, 16'h0000);
    chk("c3_ir_pc", ir_pc, 8'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      chk("seq_valid", ir_valid, 1'b1);
      chk("seq_ir", ir, 16'(k));
    end

    // Stall 3 cycles while ir=4
    @(negedge clk); stall = 1'b1; #1;
    chk("stall_ir0", ir, 16'h0004);
    chk("stall_re0", imem_re, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("stall_ir", ir, 16'h0004);
      chk("stall_valid", ir_valid, 1'b1);
      chk("stall_no_re", imem_re, 1'b0);
    end
    @(negedge clk); stall = 1'b0; #1;
    chk("release_ir", ir, 16'h0004);
    chk("release_no_re", imem_re, 1'b0);
    wait_valid("post_stall_to1", w, p);
    chk("post_stall_w1", w, 16'h0005);
    wait_valid("post_stall_to2", w, p);
    chk("post_stall_w2", w, 16'h0006);

    // Redirect under stall with a read in flight
    @(negedge clk); stall = 1'b1; redirect = 1'b1; redirect_pc = 8'h20; #1;
    chk("pre_redir_valid", ir_valid, 1'b1);
    @(negedge clk); stall = 1'b0; redirect = 1'b0; #1;
    chk("redir_flush", ir_valid, 1'b0);
    chk("redir_re", imem_re, 1'b1);
    chk("redir_addr", imem_addr, 8'h20);
    @(negedge clk); #1;
    chk("redir_no_stale", ir_valid, 1'b0);
    @(negedge clk); #1;
    chk("redir_valid", ir_valid, 1'b1);
    chk("redir_ir_pc", ir_pc, 8'h20);
    chk("redir_ir", ir, 16'h0020);

    // Halt word at address 5
    mem[5] = 16'h0001;
    @(negedge clk); redirect = 1'b1; redirect_pc = 8'h02;
    @(negedge clk); redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk); #1;
      if (ir_valid && ir_pc == 8'h05) found = 1'b1;
    end
    chk("halt_word_seen", found, 1'b1);
    chk("halt_word_ir", ir, 16'h0001);
    halt = 1'b1;
    @(negedge clk); halt = 1'b0; #1;
    chk("halted", halted, 1'b1);
    chk("halt_flush", ir_valid, 1'b0);
    chk("halt_no_re", imem_re, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("halted_hold", halted, 1'b1);
      chk("halted_no_re", imem_re, 1'b0);
      chk("halted_no_valid", ir_valid, 1'b0);
    end
    mem[5] = 16'h0005;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    chk("restart_re", imem_re, 1'b1);
    chk("restart_addr", imem_addr, 8'h0);
    chk("restart_halted", halted, 1'b0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("restart_valid", ir_valid, 1'b1);
    chk("restart_ir_pc", ir_pc, 8'h0);

    // Reset mid-operation with skid occupied
    @(negedge clk); stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ir_valid", ir_valid, 1'b0);
    chk("arst_ir", ir, 16'h0);
    chk("arst_ir_pc", ir_pc, 8'h0);
    chk("arst_halted", halted, 1'b0);
    chk("arst_re", imem_re, 1'b0);
    chk("arst_addr", imem_addr, 8'h0);
    @(negedge clk); rst_n = 1'b1; stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("post_rst_no_valid", ir_valid, 1'b0);
      chk("post_rst_no_re", imem_re, 1'b0);
    end

    // Randomized stall/redirect against the delivered-stream model
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    exp_pc = 8'h0;
    delivered = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      stall       = ($urandom_range(0, 99) < 30);
      redirect    = ($urandom_range(0, 99) < 5);
      redirect_pc = 8'($urandom);
      #1;
      if (ir_valid) begin
        chk("rnd_ir_pc", ir_pc, exp_pc);
        chk("rnd_ir", ir, mem[ir_pc]);
      end
      if (redirect) exp_pc = redirect_pc;
      else if (ir_valid && !stall) begin
        exp_pc = exp_pc + 8'd1;
        delivered++;
      end
    end
    chk("rnd_progress", 32'(delivered > 60), 1'b1);
    @(negedge clk); stall = 1'b0; redirect = 1'b0;

    // AW=4 wrap: 14, 15, 0, 1
    wrap_exp = '{4'd14, 4'd15, 4'd0, 4'd1};
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("wrap_valid", ir_valid4, 1'b1);
      chk("wrap_ir_pc", ir_pc4, wrap_exp[k]);
      chk("wrap_ir", ir4, 16'h5a00 | 16'(wrap_exp[k]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
